// File: rtl/datapath_control_pkg.sv
// Shared types and encodings for the datapath control FSM and its instruction decoder.
package datapath_control_pkg;

    // Control FSM states
    typedef enum logic [3:0] {
        StWait,
        StDecode,
        StWriteImm,
        StGetA,
        StGetB,
        StExec,
        StWriteReg,
        StAddr,
        StLoadAddr,
        StMemRd,
        StMemWb,
        StGetRd,
        StPassB,
        StMemWr,
        StHalt
    } state_e;

    // Instruction classes produced by the decoder
    typedef enum logic [2:0] {
        ClsIllegal,
        ClsMovi,
        ClsMov,
        ClsAlu,
        ClsLdr,
        ClsStr,
        ClsHalt
    } instr_cls_e;

    // Opcode field IR[15:13]
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_HALT = 3'b111;

    // Op field IR[12:11] for the move opcode
    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_MOVI = 2'b10;

    // Register-file write-data select
    localparam logic [1:0] VSEL_MDATA  = 2'b00;
    localparam logic [1:0] VSEL_SXIMM8 = 2'b01;
    localparam logic [1:0] VSEL_PC     = 2'b10;
    localparam logic [1:0] VSEL_C      = 2'b11;

    // Memory commands
    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    // ALU operations
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

endpackage

// File: rtl/datapath_control_instr_decode.sv
// Combinational instruction decoder: splits the latched IR into class, register fields,
// shifter op and ALU op.
module datapath_control_instr_decode
    import datapath_control_pkg::*;
(
    input  logic [15:0] ir,
    output instr_cls_e  cls,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [2:0]  rm,
    output logic [1:0]  shift,
    output logic [1:0]  aluop,
    output logic        is_cmp
);

    logic [2:0] opcode;
    logic [1:0] op;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign shift  = ir[4:3];
    assign rm     = ir[2:0];

    // Classify the instruction; unknown opcode/op pairs fall through to illegal
    always_comb begin
        cls = ClsIllegal;
        case (opcode)
            OPC_MOV: begin
                if (op == OP_MOVI) begin
                    cls = ClsMovi;
                end else if (op == OP_MOV) begin
                    cls = ClsMov;
                end
            end
            OPC_ALU:  cls = ClsAlu;
            OPC_LDR:  cls = ClsLdr;
            OPC_STR:  cls = ClsStr;
            OPC_HALT: cls = ClsHalt;
            default:  cls = ClsIllegal;
        endcase
    end

    // Only ALU instructions use the op field as the ALU operation; everything else adds
    assign aluop  = (cls == ClsAlu) ? op : ALU_ADD;
    assign is_cmp = (cls == ClsAlu) && (op == ALU_SUB);

endmodule

// File: rtl/datapath_control.sv
// Multi-cycle control FSM for the 16-bit datapath: latches an instruction on start and
// sequences register reads, ALU/status loads, memory commands and the register write.
module datapath_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s,
    input  logic [15:0] instr,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  aluop,
    output logic        load_addr,
    output logic [1:0]  mem_cmd
);

    import datapath_control_pkg::*;

    state_e      state_q, state_d;
    logic [15:0] ir_q;

    instr_cls_e  cls;
    logic [2:0]  rn, rd, rm;
    logic [1:0]  ir_shift, ir_aluop;
    logic        is_cmp;

    datapath_control_instr_decode u_instr_decode (
        .ir     (ir_q),
        .cls    (cls),
        .rn     (rn),
        .rd     (rd),
        .rm     (rm),
        .shift  (ir_shift),
        .aluop  (ir_aluop),
        .is_cmp (is_cmp)
    );

    // State and instruction register; IR loads only when start is accepted in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StWait;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StWait && s) begin
                ir_q <= instr;
            end
        end
    end

    // Next-state sequencing per instruction class
    always_comb begin
        state_d = state_q;
        case (state_q)
            StWait:     if (s) state_d = StDecode;
            StDecode: begin
                case (cls)
                    ClsMovi:                state_d = StWriteImm;
                    ClsMov:                 state_d = StGetB;
                    ClsAlu, ClsLdr, ClsStr: state_d = StGetA;
                    ClsHalt:                state_d = StHalt;
                    default:                state_d = StWait;
                endcase
            end
            StWriteImm: state_d = StWait;
            StGetA:     state_d = (cls == ClsAlu) ? StGetB : StAddr;
            StGetB:     state_d = StExec;
            StExec:     state_d = is_cmp ? StWait : StWriteReg;
            StWriteReg: state_d = StWait;
            StAddr:     state_d = StLoadAddr;
            StLoadAddr: state_d = (cls == ClsLdr) ? StMemRd : StGetRd;
            StMemRd:    state_d = StMemWb;
            StMemWb:    state_d = StWait;
            StGetRd:    state_d = StPassB;
            StPassB:    state_d = StMemWr;
            StMemWr:    state_d = StWait;
            StHalt:     state_d = StHalt;
            default:    state_d = StWait;
        endcase
    end

    // Moore output decode from state and latched IR fields
    always_comb begin
        w         = 1'b0;
        readnum   = 3'd0;
        writenum  = 3'd0;
        write     = 1'b0;
        vsel      = VSEL_MDATA;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        shift     = 2'b00;
        aluop     = ALU_ADD;
        load_addr = 1'b0;
        mem_cmd   = MEM_NONE;
        case (state_q)
            StWait: w = 1'b1;
            StWriteImm: begin
                write    = 1'b1;
                writenum = rn;
                vsel     = VSEL_SXIMM8;
            end
            StGetA: begin
                readnum = rn;
                loada   = 1'b1;
            end
            StGetB: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            StExec: begin
                shift = ir_shift;
                aluop = ir_aluop;
                asel  = (cls == ClsMov);
                loads = is_cmp;
                loadc = !is_cmp;
            end
            StWriteReg: begin
                write    = 1'b1;
                writenum = rd;
                vsel     = VSEL_C;
            end
            StAddr: begin
                bsel  = 1'b1;
                loadc = 1'b1;
            end
            StLoadAddr: load_addr = 1'b1;
            StMemRd:    mem_cmd = MEM_READ;
            StMemWb: begin
                mem_cmd  = MEM_READ;
                write    = 1'b1;
                writenum = rd;
                vsel     = VSEL_MDATA;
            end
            StGetRd: begin
                readnum = rd;
                loadb   = 1'b1;
            end
            StPassB: begin
                asel  = 1'b1;
                loadc = 1'b1;
            end
            StMemWr: mem_cmd = MEM_WRITE;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_datapath_control.sv
// Bench for datapath_control: a behavioural datapath/memory is driven by the DUT's strobes,
// an ISA-level model predicts writes, stores, status and per-instruction cycle counts.
module tb_datapath_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s = 1'b0;
    logic [15:0] instr = 16'h0;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel, load_addr;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, shift, aluop, mem_cmd;

    datapath_control dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s         (s),
        .instr     (instr),
        .w         (w),
        .readnum   (readnum),
        .writenum  (writenum),
        .write     (write),
        .vsel      (vsel),
        .loada     (loada),
        .loadb     (loadb),
        .loadc     (loadc),
        .loads     (loads),
        .asel      (asel),
        .bsel      (bsel),
        .shift     (shift),
        .aluop     (aluop),
        .load_addr (load_addr),
        .mem_cmd   (mem_cmd)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    logic [21:0] strobes;
    assign strobes = {readnum, writenum, write, vsel, loada, loadb, loadc, loads, asel, bsel,
                      shift, aluop, load_addr, mem_cmd};

    task automatic chk(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    endtask

    // ---------------- helpers shared by environment and model ----------------
    function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] sh);
        case (sh)
            2'b01:   return v << 1;
            2'b10:   return v >> 1;
            2'b11:   return {v[15], v[15:1]};
            default: return v;
        endcase
    endfunction

    function automatic logic [15:0] sx5(input logic [15:0] v);
        return {{11{v[4]}}, v[4:0]};
    endfunction

    function automatic logic [15:0] sx8(input logic [15:0] v);
        return {{8{v[7]}}, v[7:0]};
    endfunction

    function automatic logic [15:0] rf_init(input int i);
        return 16'(i) * 16'h1111 + 16'h0007;
    endfunction

    function automatic logic [15:0] mem_init(input int i);
        return (16'(i) * 16'h0123) ^ 16'h5A5A;
    endfunction

    // ---------------- behavioural datapath environment ----------------
    logic [15:0] rf [8];
    logic [15:0] mem [256];
    logic [15:0] ra, rb, rc, ain, bin, alu_out, wdata;
    logic [7:0]  mar;
    logic [15:0] cur_ir = 16'h0;
    bit          env_ready = 1'b0;

    always_comb begin
        ain = asel ? 16'h0 : ra;
        bin = bsel ? sx5(cur_ir) : shf(rb, shift);
        case (aluop)
            2'b00:   alu_out = ain + bin;
            2'b01:   alu_out = ain - bin;
            2'b10:   alu_out = ain & bin;
            default: alu_out = ~bin;
        endcase
        case (vsel)
            2'b00:   wdata = mem[mar];
            2'b01:   wdata = sx8(cur_ir);
            2'b11:   wdata = rc;
            default: wdata = 16'h0;
        endcase
    end

    always @(posedge clk) begin
        if (!env_ready) begin
            for (int i = 0; i < 8; i++) rf[i] <= rf_init(i);
            for (int i = 0; i < 256; i++) mem[i] <= mem_init(i);
            ra <= 16'h0;
            rb <= 16'h0;
            rc <= 16'h0;
            mar <= 8'h0;
            env_ready <= 1'b1;
        end else begin
            if (rst_n && w && s) cur_ir <= instr;
            if (loada) ra <= rf[readnum];
            if (loadb) rb <= rf[readnum];
            if (loadc) rc <= alu_out;
            if (load_addr) mar <= rc[7:0];
            if (write) rf[writenum] <= wdata;
            if (mem_cmd == 2'b10) mem[mar] <= rc;
        end
    end

    // ---------------- ISA-level reference model and scoreboard queues ----------------
    typedef struct {
        int cyc;
        int nw;
        int nl;
        int nr;
        int nm;
    } rec_t;
    typedef struct {
        logic [2:0]  num;
        logic [15:0] val;
    } wr_t;
    typedef struct {
        logic [7:0]  addr;
        logic [15:0] val;
    } st_t;

    rec_t rec_q[$];
    wr_t  wr_q[$];
    st_t  st_q[$];
    bit   z_q[$];

    logic [15:0] regs_m [8];
    logic [15:0] mem_m [256];

    task automatic model(input logic [15:0] ins);
        logic [2:0]  opc, rn, rd, rm;
        logic [1:0]  op, sh;
        logic [15:0] a, b, r;
        logic [7:0]  addr;
        opc = ins[15:13]; op = ins[12:11]; rn = ins[10:8]; rd = ins[7:5];
        sh = ins[4:3]; rm = ins[2:0];
        if (opc == 3'b110 && op == 2'b10) begin
            regs_m[rn] = sx8(ins);
            wr_q.push_back('{rn, sx8(ins)});
            rec_q.push_back('{2, 1, 0, 0, 0});
        end else if (opc == 3'b110 && op == 2'b00) begin
            r = shf(regs_m[rm], sh);
            regs_m[rd] = r;
            wr_q.push_back('{rd, r});
            rec_q.push_back('{4, 1, 0, 0, 0});
        end else if (opc == 3'b101) begin
            a = regs_m[rn];
            b = shf(regs_m[rm], sh);
            if (op == 2'b01) begin
                z_q.push_back((a - b) == 16'h0);
                rec_q.push_back('{4, 0, 1, 0, 0});
            end else begin
                r = (op == 2'b00) ? a + b : (op == 2'b10) ? (a & b) : ~b;
                regs_m[rd] = r;
                wr_q.push_back('{rd, r});
                rec_q.push_back('{5, 1, 0, 0, 0});
            end
        end else if (opc == 3'b011) begin
            addr = 8'(regs_m[rn] + sx5(ins));
            regs_m[rd] = mem_m[addr];
            wr_q.push_back('{rd, mem_m[addr]});
            rec_q.push_back('{6, 1, 0, 2, 0});
        end else if (opc == 3'b100) begin
            addr = 8'(regs_m[rn] + sx5(ins));
            mem_m[addr] = regs_m[rd];
            st_q.push_back('{addr, regs_m[rd]});
            rec_q.push_back('{7, 0, 0, 0, 1});
        end else begin
            rec_q.push_back('{1, 0, 0, 0, 0});
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        int busy, cw, cl, cr, cm;
        rec_t r;
        wr_t  e;
        st_t  t;
        bit   z;
        busy = 0; cw = 0; cl = 0; cr = 0; cm = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || !mon_en) begin
                busy = 0; cw = 0; cl = 0; cr = 0; cm = 0;
            end else if (!w) begin
                busy++;
                if (write) begin
                    cw++;
                    if (wr_q.size() == 0) chk(1'b0, "unexpected_write", 32'(writenum), 0);
                    else begin
                        e = wr_q.pop_front();
                        chk(writenum == e.num, "writenum", 32'(writenum), 32'(e.num));
                        chk(wdata == e.val, "write_data", 32'(wdata), 32'(e.val));
                    end
                end
                if (loads) begin
                    cl++;
                    if (z_q.size() == 0) chk(1'b0, "unexpected_loads", 1, 0);
                    else begin
                        z = z_q.pop_front();
                        chk((alu_out == 16'h0) == z, "status_z", 32'(alu_out == 16'h0), 32'(z));
                    end
                end
                if (mem_cmd == 2'b01) cr++;
                if (mem_cmd == 2'b10) begin
                    cm++;
                    if (st_q.size() == 0) chk(1'b0, "unexpected_store", 32'(mar), 0);
                    else begin
                        t = st_q.pop_front();
                        chk(mar == t.addr, "store_addr", 32'(mar), 32'(t.addr));
                        chk(rc == t.val, "store_data", 32'(rc), 32'(t.val));
                    end
                end
            end else begin
                chk(strobes == 22'h0, "idle_strobes", 32'(strobes), 0);
                if (busy > 0) begin
                    if (rec_q.size() == 0) chk(1'b0, "unexpected_instr", 32'(busy), 0);
                    else begin
                        r = rec_q.pop_front();
                        chk(busy == r.cyc, "latency", 32'(busy), 32'(r.cyc));
                        chk({8'(cw), 8'(cl), 8'(cr), 8'(cm)} == {8'(r.nw), 8'(r.nl), 8'(r.nr),
                            8'(r.nm)}, "strobe_counts", {8'(cw), 8'(cl), 8'(cr), 8'(cm)},
                            {8'(r.nw), 8'(r.nl), 8'(r.nr), 8'(r.nm)});
                    end
                end
                busy = 0; cw = 0; cl = 0; cr = 0; cm = 0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!w) begin
            n++;
            if (n > 50) begin
                chk(1'b0, "timeout_waiting_for_w", 32'(w), 1);
                summary();
                $finish;
            end
            @(negedge clk);
        end
    endtask

    task automatic issue(input logic [15:0] ins, input bit hold);
        wait_idle();
        model(ins);
        instr = ins;
        s = 1'b1;
        @(posedge clk);
        #1;
        chk(!w, "captured", 32'(w), 0);
        instr = 16'($urandom);
        if (!hold) s = 1'b0;
    endtask

    task automatic drain();
        s = 1'b0;
        wait_idle();
        @(posedge clk);
    endtask

    function automatic logic [15:0] rand_instr();
        int k;
        logic [15:0] r;
        k = $urandom_range(0, 9);
        r = 16'($urandom);
        case (k)
            0: r[15:11] = 5'b11010;
            1: r[15:11] = 5'b11000;
            5: r[15:11] = 5'b01100;
            6: r[15:11] = 5'b10000;
            7: r[15:13] = 3'($urandom_range(0, 2));
            8: r[15:11] = ($urandom_range(0, 1) == 0) ? 5'b11001 : 5'b11011;
            default: r[15:13] = 3'b101;
        endcase
        return r;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [15:0] keep;
        for (int i = 0; i < 8; i++) regs_m[i] = rf_init(i);
        for (int i = 0; i < 256; i++) mem_m[i] = mem_init(i);

        // reset state
        #1;
        chk(w == 1'b1, "reset_w", 32'(w), 1);
        chk(strobes == 22'h0, "reset_outputs", 32'(strobes), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        mon_en = 1'b1;

        // directed: MOVI R3,#5; ADD; CMP; LDR; STR; illegal
        issue(16'hD305, 1'b0);
        issue(16'hA128, 1'b0);
        issue(16'hA900, 1'b0);
        issue(16'h6182, 1'b0);
        issue(16'h8182, 1'b0);
        issue(16'h0000, 1'b0);

        // back-to-back MOVIs with start held high
        issue(16'hD0A5, 1'b1);
        issue(16'hD1F0, 1'b1);
        issue(16'hD27F, 1'b0);

        // randomized mix
        for (int i = 0; i < 300; i++) issue(rand_instr(), 1'($urandom_range(0, 1)));
        drain();
        mon_en = 1'b0;

        // reset during LDR's MEM_RD: no write, strobes drop at once
        keep = rf[4];
        wait_idle();
        instr = 16'h6182;
        s = 1'b1;
        @(posedge clk);
        #1 s = 1'b0;
        n = 0;
        while (mem_cmd != 2'b01 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(mem_cmd == 2'b01, "reach_mem_rd", 32'(mem_cmd), 1);
        #2 rst_n = 1'b0;
        #1;
        chk({mem_cmd, write} == 3'b000, "reset_drops_strobes", 32'({mem_cmd, write}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk(w == 1'b1, "wait_after_reset", 32'(w), 1);
        chk(rf[4] == keep, "no_partial_write", 32'(rf[4]), 32'(keep));
        @(posedge clk);
        mon_en = 1'b1;
        issue(16'h0000, 1'b0);
        issue(16'h1F3C, 1'b0);
        drain();
        mon_en = 1'b0;

        // HALT: w stays low and s is ignored until reset
        wait_idle();
        instr = 16'hE000;
        s = 1'b1;
        @(posedge clk);
        #1 s = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk(!w && strobes == 22'h0, "halt_quiet", 32'({w, strobes}), 0);
            s = 1'($urandom_range(0, 1));
            instr = 16'hD305;
        end
        s = 1'b0;
        rst_n = 1'b0;
        #1;
        chk(w == 1'b1, "halt_exit_on_reset", 32'(w), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // final state
        chk(rec_q.size() == 0 && wr_q.size() == 0 && st_q.size() == 0 && z_q.size() == 0,
            "queues_drained", 32'(rec_q.size() + wr_q.size() + st_q.size() + z_q.size()), 0);
        for (int i = 0; i < 8; i++) chk(rf[i] == regs_m[i], "regfile", 32'(rf[i]), 32'(regs_m[i]));
        summary();
        $finish;
    end

endmodule
